// File: rtl/shared_mem_playback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shared_mem_playback_ctrl_if
// Purpose  : Read-port bundle between the playback sequencer and port s2 of
//            the dual-port shared sample memory.
// Signals  : mem_address    - word address (registered inside the RAM)
//            mem_chipselect - read strobe, one cycle per word
//            mem_write      - write strobe (the sequencer only reads)
//            mem_byteenable - byte lanes
//            mem_readdata   - read data, valid the cycle after the request
// Revision : 1.0 - initial release
// ============================================================================
interface shared_mem_playback_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_readdata;

    modport master (
        output mem_address,
        output mem_chipselect,
        output mem_write,
        output mem_byteenable,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_chipselect,
        input  mem_write,
        input  mem_byteenable,
        output mem_readdata
    );
endinterface
`default_nettype wire

// File: rtl/shared_mem_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shared_mem_playback_ctrl
// Purpose  : Fetches stereo sample words from a ring buffer in the shared
//            sample memory, holds them in a prefetch FIFO and emits one
//            sample per sample_tick. Flags underruns with a sticky bit.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            enable              - playback enable
//            wr_ptr / rd_ptr     - CPU write index / next index to fetch
//            mem                 - memory read port (master modport)
//            sample_tick         - frame-rate strobe
//            sample_valid/left/right - sample output, one-cycle valid pulse
//            underrun / underrun_clr - sticky underrun flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module shared_mem_playback_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int RING_BASE  = 0,
    parameter int RING_WORDS = 8192,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [ADDR_W-1:0]          wr_ptr,
    output logic [ADDR_W-1:0]          rd_ptr,
    shared_mem_playback_ctrl_if.master mem,
    input  logic                       sample_tick,
    output logic                       sample_valid,
    output logic [15:0]                sample_left,
    output logic [15:0]                sample_right,
    output logic                       underrun,
    input  logic                       underrun_clr
);

    localparam int c_IDX_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_IDX_W + 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;

    localparam logic [ADDR_W-1:0]  c_LAST       = ADDR_W'(RING_WORDS - 1);
    localparam logic [ADDR_W-1:0]  c_BASE       = ADDR_W'(RING_BASE);
    localparam logic [ADDR_W:0]    c_RING_WORDS = (ADDR_W + 1)'(RING_WORDS);
    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_cs;
    logic [31:0]        r_fifo [FIFO_DEPTH];
    logic [c_IDX_W-1:0] r_fifo_wr;
    logic [c_IDX_W-1:0] r_fifo_rd;
    logic [c_CNT_W-1:0] r_fifo_cnt;
    logic               r_valid;
    logic [15:0]        r_left;
    logic [15:0]        r_right;
    logic               r_underrun;

    logic [ADDR_W-1:0]  w_rd_next;
    logic               w_wr_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_underrun_evt;
    logic               w_start_idle;
    logic               w_start_cap;

    // Ring index after the word being captured, wrapping at a possibly
    // non-power-of-two ring length.
    assign w_rd_next = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;

    // A write index outside the ring reads as "nothing to fetch".
    assign w_wr_ok = {1'b0, wr_ptr} < c_RING_WORDS;

    assign w_push         = enable && (r_state == c_ST_CAPTURE);
    assign w_pop          = sample_tick && enable && (r_fifo_cnt != '0);
    assign w_underrun_evt = sample_tick && enable && (r_fifo_cnt == '0);

    // Room accounting reserves a slot for the read in flight: in CAPTURE the
    // arriving word is not yet counted in r_fifo_cnt.
    assign w_start_idle = enable && w_wr_ok && (r_rd_ptr != wr_ptr) &&
                          (r_fifo_cnt < c_DEPTH);
    assign w_start_cap  = enable && w_wr_ok && (w_rd_next != wr_ptr) &&
                          ((r_fifo_cnt + c_CNT_ONE) < c_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_rd_ptr   <= '0;
            r_mem_addr <= c_BASE;
            r_mem_cs   <= 1'b0;
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            r_fifo_cnt <= '0;
            r_valid    <= 1'b0;
            r_left     <= '0;
            r_right    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_mem_cs <= 1'b0;

            // Every tick yields a pulse; silence when disabled or starved.
            if (sample_tick) begin
                r_valid <= 1'b1;
                if (w_pop) begin
                    r_left    <= r_fifo[r_fifo_rd][31:16];
                    r_right   <= r_fifo[r_fifo_rd][15:0];
                    r_fifo_rd <= r_fifo_rd + c_IDX_ONE;
                end else begin
                    r_left  <= '0;
                    r_right <= '0;
                end
            end

            if (w_push) begin
                r_fifo[r_fifo_wr] <= mem.mem_readdata;
                r_fifo_wr         <= r_fifo_wr + c_IDX_ONE;
            end

            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - c_CNT_ONE;
            end

            // Set has priority over clear.
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end

            if (!enable) begin
                // Flush and park; a read in flight is dropped and rd_ptr
                // keeps pointing at the first word not yet delivered.
                r_state    <= c_ST_IDLE;
                r_fifo_wr  <= '0;
                r_fifo_rd  <= '0;
                r_fifo_cnt <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_start_idle) begin
                            r_state    <= c_ST_ISSUE;
                            r_mem_cs   <= 1'b1;
                            r_mem_addr <= c_BASE + r_rd_ptr;
                        end
                    end
                    c_ST_ISSUE: begin
                        r_state <= c_ST_CAPTURE;
                    end
                    c_ST_CAPTURE: begin
                        r_rd_ptr <= w_rd_next;
                        if (w_start_cap) begin
                            r_state    <= c_ST_ISSUE;
                            r_mem_cs   <= 1'b1;
                            r_mem_addr <= c_BASE + w_rd_next;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_ptr             = r_rd_ptr;
    assign mem.mem_address    = r_mem_addr;
    assign mem.mem_chipselect = r_mem_cs;
    assign mem.mem_write      = 1'b0;
    assign mem.mem_byteenable = 4'hF;
    assign sample_valid       = r_valid;
    assign sample_left        = r_left;
    assign sample_right       = r_right;
    assign underrun           = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_playback_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shared_mem_playback_ctrl
// Purpose  : Self-checking bench. Instance A uses the default 8192-word ring
//            and is driven by a vector table and hand-written sequences.
//            Instance B uses a small offset ring with a 2-entry FIFO and is
//            driven randomly against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_mem_playback_ctrl;

    localparam int AW      = 13;
    localparam int B_BASE  = 20;
    localparam int B_WORDS = 11;
    localparam int B_DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A ----------------
    logic          a_reset = 1'b1;
    logic          a_en    = 1'b0;
    logic          a_tick  = 1'b0;
    logic          a_clr   = 1'b0;
    logic [AW-1:0] a_wr    = '0;
    logic [AW-1:0] a_rd;
    logic          a_valid;
    logic          a_und;
    logic [15:0]   a_left;
    logic [15:0]   a_right;

    shared_mem_playback_ctrl_if #(.ADDR_W(AW)) a_bus ();

    shared_mem_playback_ctrl #(.ADDR_W(AW)) dut_a (
        .clk          (clk),
        .reset        (a_reset),
        .enable       (a_en),
        .wr_ptr       (a_wr),
        .rd_ptr       (a_rd),
        .mem          (a_bus),
        .sample_tick  (a_tick),
        .sample_valid (a_valid),
        .sample_left  (a_left),
        .sample_right (a_right),
        .underrun     (a_und),
        .underrun_clr (a_clr)
    );

    logic [31:0]   mem_a [8192];
    logic [AW-1:0] a_raddr = '0;
    always @(posedge clk) a_raddr <= a_bus.mem_address;
    assign a_bus.mem_readdata = mem_a[a_raddr];

    // ---------------- instance B ----------------
    logic          b_reset = 1'b1;
    logic          b_en    = 1'b0;
    logic          b_tick  = 1'b0;
    logic          b_clr   = 1'b0;
    logic [AW-1:0] b_wr    = '0;
    logic [AW-1:0] b_rd;
    logic          b_valid;
    logic          b_und;
    logic [15:0]   b_left;
    logic [15:0]   b_right;

    shared_mem_playback_ctrl_if #(.ADDR_W(AW)) b_bus ();

    shared_mem_playback_ctrl #(
        .ADDR_W(AW), .RING_BASE(B_BASE), .RING_WORDS(B_WORDS), .FIFO_DEPTH(B_DEPTH)
    ) dut_b (
        .clk          (clk),
        .reset        (b_reset),
        .enable       (b_en),
        .wr_ptr       (b_wr),
        .rd_ptr       (b_rd),
        .mem          (b_bus),
        .sample_tick  (b_tick),
        .sample_valid (b_valid),
        .sample_left  (b_left),
        .sample_right (b_right),
        .underrun     (b_und),
        .underrun_clr (b_clr)
    );

    logic [31:0]   mem_b [8192];
    logic [AW-1:0] b_raddr = '0;
    always @(posedge clk) b_raddr <= b_bus.mem_address;
    assign b_bus.mem_readdata = mem_b[b_raddr];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] seen[$];

    task automatic run_a(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (a_bus.mem_chipselect) seen.push_back(a_bus.mem_address);
        end
    endtask

    function automatic logic [31:0] seen_at(input int k);
        if (k < seen.size()) return 32'(seen[k]);
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic          en;
        logic [AW-1:0] wr;
        logic          tick;
        logic          clr;
        logic          cs;
        logic [AW-1:0] addr;
        logic [AW-1:0] rd;
        logic          valid;
        logic [31:0]   lr;
        logic          und;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input int en, input int wr, input int tick, input int clr,
                                input int cs, input int addr, input int rd, input int valid,
                                input logic [31:0] lr, input int und);
        vec_t v;
        v.en = en[0];      v.wr = wr[AW-1:0];     v.tick = tick[0]; v.clr = clr[0];
        v.cs = cs[0];      v.addr = addr[AW-1:0]; v.rd = rd[AW-1:0];
        v.valid = valid[0]; v.lr = lr;            v.und = und[0];
        return v;
    endfunction

    // ---------------- reference model for instance B ----------------
    logic [31:0] m_q[$];
    int          m_rd;
    int          m_addr;
    bit          m_cs;
    bit          m_cap;
    bit          m_valid;
    bit          m_und;
    logic [15:0] m_left;
    logic [15:0] m_right;

    // One clock of the playback rules, applied to the inputs just sampled.
    // m_cs: a read request is on the bus; m_cap: its data is on readdata.
    task automatic model_step();
        int          n0;
        bit          und_evt;
        bit          had_cs;
        bit          had_cap;
        bit          ring_has_data;
        logic [31:0] w;
        n0      = m_q.size();
        und_evt = 1'b0;
        m_valid = 1'b0;
        if (b_reset) begin
            m_q.delete();
            m_rd = 0; m_addr = B_BASE; m_cs = 1'b0; m_cap = 1'b0;
            m_left = '0; m_right = '0; m_und = 1'b0;
            return;
        end
        if (b_tick) begin
            m_valid = 1'b1;
            if (b_en && n0 > 0) begin
                w       = m_q.pop_front();
                m_left  = w[31:16];
                m_right = w[15:0];
            end else begin
                m_left  = '0;
                m_right = '0;
                und_evt = b_en;
            end
        end
        if (!b_en) begin
            m_q.delete();
            m_cs  = 1'b0;
            m_cap = 1'b0;
        end else begin
            had_cs  = m_cs;
            had_cap = m_cap;
            if (had_cap) begin
                m_q.push_back(mem_b[B_BASE + m_rd]);
                m_rd = (m_rd + 1) % B_WORDS;
            end
            ring_has_data = (int'(b_wr) < B_WORDS) && (m_rd != int'(b_wr));
            m_cap = had_cs;
            m_cs  = !had_cs && ring_has_data && ((n0 + (had_cap ? 1 : 0)) < B_DEPTH);
            if (m_cs) m_addr = B_BASE + m_rd;
        end
        if (und_evt) m_und = 1'b1;
        else if (b_clr) m_und = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem_a[i] = {16'hA000 + 16'(i), 16'h5000 + 16'(i)};
            mem_b[i] = {16'(i * 37 + 5), 16'(i) ^ 16'h3C3C};
        end
        mem_a[0] = 32'h1234_ABCD;

        //        en wr  tk clr  cs addr rd  vld lr            und
        vt[0]  = mk(1, 3, 0, 0,   1, 0,  0,  0, 32'h0,        0);
        vt[1]  = mk(1, 3, 0, 0,   0, 0,  0,  0, 32'h0,        0);
        vt[2]  = mk(1, 3, 0, 0,   1, 1,  1,  0, 32'h0,        0);
        vt[3]  = mk(1, 3, 0, 0,   0, 1,  1,  0, 32'h0,        0);
        vt[4]  = mk(1, 3, 0, 0,   1, 2,  2,  0, 32'h0,        0);
        vt[5]  = mk(1, 3, 0, 0,   0, 2,  2,  0, 32'h0,        0);
        vt[6]  = mk(1, 3, 0, 0,   0, 2,  3,  0, 32'h0,        0);
        vt[7]  = mk(1, 3, 0, 0,   0, 2,  3,  0, 32'h0,        0);
        vt[8]  = mk(1, 3, 1, 0,   0, 2,  3,  1, 32'h1234ABCD, 0);
        vt[9]  = mk(1, 3, 0, 0,   0, 2,  3,  0, 32'h1234ABCD, 0);
        vt[10] = mk(1, 3, 1, 0,   0, 2,  3,  1, 32'hA0015001, 0);
        vt[11] = mk(1, 3, 1, 0,   0, 2,  3,  1, 32'hA0025002, 0);
        vt[12] = mk(1, 3, 1, 0,   0, 2,  3,  1, 32'h0,        1);
        vt[13] = mk(1, 4, 0, 0,   1, 3,  3,  0, 32'h0,        1);
        vt[14] = mk(1, 4, 0, 0,   0, 3,  3,  0, 32'h0,        1);
        vt[15] = mk(1, 4, 0, 0,   0, 3,  4,  0, 32'h0,        1);
        vt[16] = mk(1, 4, 0, 1,   0, 3,  4,  0, 32'h0,        0);
        vt[17] = mk(1, 4, 1, 1,   0, 3,  4,  1, 32'hA0035003, 0);
        vt[18] = mk(1, 4, 1, 1,   0, 3,  4,  1, 32'h0,        1);
        vt[19] = mk(1, 4, 0, 0,   0, 3,  4,  0, 32'h0,        1);

        // Reset state
        step();
        step();
        chk("rst_rd_ptr", 32'(a_rd), 0);
        chk("rst_cs", 32'(a_bus.mem_chipselect), 0);
        chk("rst_addr", 32'(a_bus.mem_address), 0);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_samples", {a_left, a_right}, 0);
        chk("rst_underrun", 32'(a_und), 0);
        chk("mem_write", 32'(a_bus.mem_write), 0);
        chk("mem_byteenable", 32'(a_bus.mem_byteenable), 32'hF);

        // Table: basic fetch, playback, underrun set/clear
        a_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_en = vt[i].en; a_wr = vt[i].wr; a_tick = vt[i].tick; a_clr = vt[i].clr;
            step();
            chk($sformatf("vec%0d_cs", i), 32'(a_bus.mem_chipselect), 32'(vt[i].cs));
            if (vt[i].cs) chk($sformatf("vec%0d_addr", i), 32'(a_bus.mem_address), 32'(vt[i].addr));
            chk($sformatf("vec%0d_rd", i), 32'(a_rd), 32'(vt[i].rd));
            chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vt[i].valid));
            chk($sformatf("vec%0d_lr", i), {a_left, a_right}, vt[i].lr);
            chk($sformatf("vec%0d_und", i), 32'(a_und), 32'(vt[i].und));
        end
        a_tick = 1'b0; a_clr = 1'b0;

        // Reset while a read is in flight
        a_wr = 13'd100;
        for (int i = 0; i < 10 && !a_bus.mem_chipselect; i++) step();
        chk("inflight_cs", 32'(a_bus.mem_chipselect), 1);
        a_reset = 1'b1;
        step();
        chk("midrst_cs", 32'(a_bus.mem_chipselect), 0);
        chk("midrst_rd", 32'(a_rd), 0);
        chk("midrst_addr", 32'(a_bus.mem_address), 0);
        chk("midrst_und", 32'(a_und), 0);
        chk("midrst_lr", {a_left, a_right}, 0);
        a_reset = 1'b0;

        // Full FIFO: four reads then idle; one tick frees exactly one slot
        seen.delete();
        run_a(20);
        chk("full_reads", 32'(seen.size()), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("full_addr%0d", k), seen_at(k), 32'(k));
        chk("full_rd", 32'(a_rd), 4);
        seen.delete();
        a_tick = 1'b1;
        run_a(1);
        chk("full_tick_valid", 32'(a_valid), 1);
        chk("full_tick_lr", {a_left, a_right}, 32'h1234_ABCD);
        a_tick = 1'b0;
        run_a(10);
        chk("refill_reads", 32'(seen.size()), 1);
        chk("refill_addr", seen_at(0), 4);
        chk("refill_rd", 32'(a_rd), 5);

        // Disable during the CAPTURE of ring index 5
        a_tick = 1'b1;
        step();
        a_tick = 1'b0;
        for (int i = 0; i < 10 && !a_bus.mem_chipselect; i++) step();
        chk("dis_issue_addr", 32'(a_bus.mem_address), 5);
        step();
        a_en = 1'b0;
        step();
        chk("dis_rd", 32'(a_rd), 5);
        chk("dis_cs", 32'(a_bus.mem_chipselect), 0);
        step();
        step();
        chk("dis_rd_hold", 32'(a_rd), 5);
        a_en = 1'b1;
        a_tick = 1'b1;
        step();
        chk("reen_valid", 32'(a_valid), 1);
        chk("reen_lr_flushed", {a_left, a_right}, 0);
        chk("reen_und", 32'(a_und), 1);
        chk("reen_cs", 32'(a_bus.mem_chipselect), 1);
        chk("reen_addr", 32'(a_bus.mem_address), 5);
        a_tick = 1'b0;
        step();
        step();
        chk("reen_rd", 32'(a_rd), 6);

        // Wrap-around at the end of the 8192-word ring
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        a_wr = 13'd8191;
        a_tick = 1'b1;
        for (int i = 0; i < 20000 && a_rd != 13'd8191; i++) step();
        chk("wrap_reach", 32'(a_rd), 8191);
        a_wr = 13'd2;
        seen.delete();
        run_a(12);
        chk("wrap_reads", 32'(seen.size()), 3);
        chk("wrap_addr0", seen_at(0), 8191);
        chk("wrap_addr1", seen_at(1), 0);
        chk("wrap_addr2", seen_at(2), 1);
        chk("wrap_rd", 32'(a_rd), 2);
        a_tick = 1'b0;
        a_en = 1'b0;

        // Randomised run on instance B against the reference model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            b_reset = (cyc == 0) || ($urandom_range(0, 299) == 0);
            b_en    = ($urandom_range(0, 24) != 0);
            b_tick  = (cyc < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            b_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) b_wr = AW'($urandom_range(0, B_WORDS + 1));
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_cs", 32'(b_bus.mem_chipselect), 32'(m_cs));
            chk("rnd_addr", 32'(b_bus.mem_address), 32'(m_addr));
            chk("rnd_rd", 32'(b_rd), 32'(m_rd));
            chk("rnd_valid", 32'(b_valid), 32'(m_valid));
            chk("rnd_lr", {b_left, b_right}, {m_left, m_right});
            chk("rnd_und", 32'(b_und), 32'(m_und));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_mem_playback_ctrl.md
Name: shared_mem_playback_ctrl

Overview:
- Playback sequencer that owns the second (s2) port of the 8192x32 dual-port shared sample memory.
- The CPU writes stereo sample words into a ring buffer through port s1 and publishes its write index.
- This block fetches words from the ring in order, holds them in a small prefetch FIFO, and presents one stereo sample per sample-rate tick to the audio codec interface.
- It detects and flags underruns.

Parameters:
ADDR_W, 13, memory word-address width
RING_BASE, 0, first word address of the ring buffer
RING_WORDS, 8192, ring length in words (need not be a power of two; RING_BASE+RING_WORDS <= 2^ADDR_W)
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
enable  in  1  playback enable (control register bit)
wr_ptr  in  ADDR_W  CPU write index, 0..RING_WORDS-1; the next word the CPU will write
rd_ptr  out  ADDR_W  next ring index to fetch; readable by the CPU
mem_address  out  ADDR_W  to memory address2
mem_chipselect  out  1  to memory chipselect2
mem_write  out  1  to memory write2; constant 0
mem_byteenable  out  4  to memory byteenable2; constant 4'hF
mem_readdata  in  32  from memory readdata2
sample_tick  in  1  one-cycle strobe at the audio frame rate
sample_valid  out  1  one-cycle pulse carrying a new sample
sample_left  out  16  left channel, signed
sample_right  out  16  right channel, signed
underrun  out  1  sticky underrun flag
underrun_clr  in  1  clears underrun

Behaviour:
- Reset: rd_ptr=0, FIFO empty, FSM=IDLE. Outputs mem_chipselect, sample_valid, sample_left, sample_right and underrun are all 0. mem_address=RING_BASE.
- Memory timing: the address is registered in the RAM and the output is unregistered. mem_readdata for a request issued in cycle N is valid in cycle N+1. At most one read is outstanding.
- ring_empty = (rd_ptr == wr_ptr).
- room = (fifo_count + outstanding < FIFO_DEPTH).
- FSM:
  - IDLE -> ISSUE when enable & !ring_empty & room.
  - ISSUE: mem_chipselect=1 and mem_address=RING_BASE+rd_ptr for exactly one cycle. Next state is CAPTURE.
  - CAPTURE: push mem_readdata into the FIFO. rd_ptr <= (rd_ptr==RING_WORDS-1) ? 0 : rd_ptr+1. If enable & !ring_empty(after increment) & room, go to ISSUE; otherwise go to IDLE.
  - Sustained fetch rate is one word per 2 cycles.
- mem_chipselect is 0 in every state except ISSUE.
- Sample output:
  - On sample_tick with the FIFO non-empty: pop the head word. Next cycle, sample_valid=1, sample_left=word[31:16], sample_right=word[15:0].
  - On sample_tick with the FIFO empty and enable=1: next cycle, sample_valid=1 with both channels 0, and underrun<=1.
  - On sample_tick with enable=0: sample_valid pulses with zeros and underrun is not set.
  - sample_left and sample_right hold their values between pulses.
- FIFO push and pop in the same cycle are both honoured and fifo_count is unchanged. A pop of a FIFO that is empty at the start of that cycle is an underrun, even if a push lands in the same cycle.
- Underrun flag: underrun_clr clears the flag. If a new underrun event coincides with underrun_clr, the flag stays 1 (set wins).
- enable falling:
  - Next cycle the FSM goes to IDLE and the FIFO is flushed.
  - A CAPTURE in the same cycle as enable=0 is discarded and rd_ptr is not incremented.
  - rd_ptr holds its value; playback resumes from rd_ptr when enable rises.
- Reset mid-operation: returns to the reset state immediately, including a dropped in-flight read. No mem_chipselect is asserted in the reset cycle.
- wr_ptr may change in any cycle and is sampled each cycle. A wr_ptr value >= RING_WORDS is treated as ring_empty=1 (no fetch).

Test Plan:
- Basic fetch: RING_BASE=0, wr_ptr 0->3, enable=1. Required: mem_chipselect pulses at addresses 0, 1, 2 on alternate cycles; rd_ptr ends at 3; fifo_count=3; no further chipselect.
- Playback: memory[0]=32'h1234_ABCD, tick once. Required: sample_valid one cycle after the tick, with left=16'h1234 and right=16'hABCD.
- Full FIFO: wr_ptr=100, no ticks. Required: exactly 4 reads, then idle. One tick -> exactly one further read, at address 4.
- Wrap-around: RING_WORDS=8192, rd_ptr=8191, wr_ptr=2. Required: reads at addresses 8191, 0, 1; rd_ptr=2.
- Underrun: empty ring, enable=1, tick. Required: sample_valid with zeros and underrun=1. Underrun stays 1 after refill. Pulse underrun_clr -> underrun=0. Clear coincident with a new underrun -> underrun=1.
- Disable mid-fetch: deassert enable in a CAPTURE cycle at rd_ptr=5. Required: rd_ptr stays 5 and FIFO empty. Re-enable -> the next read address is 5.
